restoring_divider: RTL and testbench

//   Sequential unsigned WIDTH-bit divider producing quotient and remainder.

---
 rtl/restoring_divider.sv | 111 +++++++++++
 tb/tb_restoring_divider.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift-subtract-restore step per
// clock, WIDTH steps per operation. A zero divisor bypasses the iteration and
// reports all-ones quotient, remainder = dividend, and a div_by_zero flag.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d_work;

  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction {r, msb} - {0, d}, done as an add of the inverted
  // divisor with carry-in 1, matching the ALU adder's subtract path.
  // Because r < d always holds, bit WIDTH of the result is 0 exactly when
  // the subtraction did not borrow.
  function automatic logic [WIDTH:0] sub_step(
    input logic [WIDTH-1:0] r,
    input logic             msb,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] t;
    t = {r, msb} + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};
    return t;
  endfunction

  // One restoring step: keep the difference on no-borrow, otherwise just shift.
  always_comb begin
    trial     = sub_step(r_work, q_work[WIDTH-1], d_work);
    no_borrow = ~trial[WIDTH];
    r_next    = no_borrow ? trial[WIDTH-1:0] : {r_work[WIDTH-2:0], q_work[WIDTH-1]};
    q_next    = {q_work[WIDTH-2:0], no_borrow};
  end

  assign busy = (state == DIV);
  assign done = (state == DONE);

  // Control FSM, working registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_work      <= '0;
      q_work      <= '0;
      d_work      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              r_work <= '0;
              q_work <= dividend;
              d_work <= divisor;
              cnt    <= '0;
              state  <= DIV;
            end
          end
        end
        DIV: begin
          r_work <= r_next;
          q_work <= q_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus randomised
// operands compared against plain integer division.
module tb_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = a[WIDTH-1:0];
    divisor  = b[WIDTH-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done is seen, and busy cycles on the way; bounded.
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!done && edges < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      edges++;
    end
    if (!done) check("done_timeout", 0, 1);
    else if (busy) check("busy_with_done", 1, 0);
  endtask

  // Full transaction against the reference model, including latency and pulse width.
  task automatic run_check(input int a, input int b, input string tag);
    int edges, busy_n;
    int eq, er, ez, elat;
    if (b == 0) begin
      eq = (1 << WIDTH) - 1; er = a; ez = 1; elat = 0;
    end else begin
      eq = a / b; er = a % b; ez = 0; elat = WIDTH;
    end
    launch(a, b);
    wait_done(edges, busy_n);
    check({tag, "_q"}, int'(quotient), eq);
    check({tag, "_r"}, int'(remainder), er);
    check({tag, "_dbz"}, int'(div_by_zero), ez);
    check({tag, "_latency"}, edges, elat);
    check({tag, "_busy_cycles"}, busy_n, elat);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int edges, busy_n, done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_check(200, 7, "d200_7");
    run_check(255, 1, "d255_1");
    run_check(5, 9, "d5_9");
    run_check(0, 3, "d0_3");
    run_check(77, 0, "d77_0");
    run_check(255, 255, "d255_255");
    run_check(254, 255, "d254_255");

    // Start during DIV is ignored; input changes after capture have no effect
    launch(100, 3);
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, busy_n);
    check("ign_q", int'(quotient), 33);
    check("ign_r", int'(remainder), 1);
    @(negedge clk);
    check("ign_done_pulse", int'(done), 0);
    // Back-to-back start in the first IDLE cycle; old result held meanwhile
    launch(50, 5);
    check("b2b_busy", int'(busy), 1);
    @(negedge clk);
    check("hold_q", int'(quotient), 33);
    check("hold_r", int'(remainder), 1);
    wait_done(edges, busy_n);
    check("b2b_latency", edges + 1, WIDTH);
    check("b2b_q", int'(quotient), 10);
    check("b2b_r", int'(remainder), 0);
    @(negedge clk);

    // Reset in the middle of a division
    run_check(200, 7, "pre_rst");
    launch(200, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_q", int'(quotient), 0);
    check("mid_rst_r", int'(remainder), 0);
    check("mid_rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    run_check(9, 2, "d9_2");

    // Randomised operands, nonzero divisor
    for (int i = 0; i < 1000; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << WIDTH) - 1));
      b = int'($urandom_range(1, (1 << WIDTH) - 1));
      run_check(a, b, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
